// File: rtl/demux_pkg.sv
// Shared types and sizing for the 8-channel TDM demultiplexer.
// Holds the framing FSM state enum, the channel count and the channel index width.
package demux_pkg;

    localparam int NCH  = 8;
    localparam int CH_W = 3;

    typedef enum logic {
        HUNT = 1'b0,
        LOCK = 1'b1
    } state_t;

endpackage

// File: rtl/ch_decoder_3to8.sv
// Channel index to one-hot write vector, gated by an enable.
// Ports: sel (channel index), en (write enable), onehot (per-channel write strobe).
module ch_decoder_3to8
    import demux_pkg::*;
(
    input  logic [CH_W-1:0] sel,
    input  logic            en,
    output logic [NCH-1:0]  onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/demux_8ch_tdm.sv
// Serial TDM demultiplexer: routes one din bit per valid cycle to 8 held channels.
// Ports: clk, rst (sync, active-high), din, din_valid, frame_sync in;
//        y, y_stb, frame_done, locked, sync_err out (all registered).
module demux_8ch_tdm
    import demux_pkg::*;
#(
    parameter int NCH = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           din,
    input  logic           din_valid,
    input  logic           frame_sync,
    output logic [NCH-1:0] y,
    output logic [NCH-1:0] y_stb,
    output logic           frame_done,
    output logic           locked,
    output logic           sync_err
);

    state_t            state;
    state_t            state_nxt;
    logic [CH_W-1:0]   ch_cnt;
    logic [CH_W-1:0]   ch_nxt;
    logic [CH_W-1:0]   wr_sel;
    logic              wr_en;
    logic              err_nxt;
    logic [NCH-1:0]    wr_vec;

    ch_decoder_3to8 u_dec (
        .sel    (wr_sel),
        .en     (wr_en),
        .onehot (wr_vec)
    );

    // A sync sample always lands on channel 0 and restarts the count at 1;
    // it is only an error when it arrives mid-frame while locked.
    always_comb begin
        state_nxt = state;
        ch_nxt    = ch_cnt;
        wr_sel    = ch_cnt;
        wr_en     = 1'b0;
        err_nxt   = 1'b0;
        if (din_valid) begin
            unique case (state)
                HUNT: begin
                    if (frame_sync) begin
                        wr_en     = 1'b1;
                        wr_sel    = '0;
                        ch_nxt    = CH_W'(1);
                        state_nxt = LOCK;
                    end
                end
                LOCK: begin
                    wr_en = 1'b1;
                    if (frame_sync) begin
                        wr_sel  = '0;
                        ch_nxt  = CH_W'(1);
                        err_nxt = (ch_cnt != '0);
                    end else begin
                        wr_sel = ch_cnt;
                        ch_nxt = ch_cnt + CH_W'(1);
                    end
                end
                default: begin
                    state_nxt = HUNT;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= HUNT;
            ch_cnt     <= '0;
            y          <= '0;
            y_stb      <= '0;
            frame_done <= 1'b0;
            sync_err   <= 1'b0;
            locked     <= 1'b0;
        end else begin
            state      <= state_nxt;
            ch_cnt     <= ch_nxt;
            y          <= (y & ~wr_vec) | (wr_vec & {NCH{din}});
            y_stb      <= wr_vec;
            frame_done <= wr_vec[NCH-1];
            sync_err   <= err_nxt;
            locked     <= (state_nxt == LOCK);
        end
    end

endmodule

// File: tb/tb_demux_8ch_tdm.sv
// Directed scoreboard bench for demux_8ch_tdm.
// Driver queues hand-computed responses; a negedge monitor pops and compares.
module tb_demux_8ch_tdm;

    logic       clk = 1'b0;
    logic       rst;
    logic       din;
    logic       din_valid;
    logic       frame_sync;
    logic [7:0] y;
    logic [7:0] y_stb;
    logic       frame_done;
    logic       locked;
    logic       sync_err;

    typedef struct packed {
        logic [7:0] y;
        logic [7:0] stb;
        logic       fd;
        logic       lk;
        logic       er;
    } exp_t;

    typedef struct packed {
        logic rst;
        logic v;
        logic fs;
        logic d;
        exp_t e;
    } vec_t;

    vec_t vecs[$];
    exp_t exp_q[$];
    int   idx_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    demux_8ch_tdm #(.NCH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .frame_sync (frame_sync),
        .y          (y),
        .y_stb      (y_stb),
        .frame_done (frame_done),
        .locked     (locked),
        .sync_err   (sync_err)
    );

    task automatic add(input logic r, input logic v, input logic fs,
                       input logic d, input logic [7:0] ey,
                       input logic [7:0] es, input logic fd,
                       input logic lk, input logic er);
        vec_t t;
        t.rst  = r;
        t.v    = v;
        t.fs   = fs;
        t.d    = d;
        t.e.y  = ey;
        t.e.stb = es;
        t.e.fd = fd;
        t.e.lk = lk;
        t.e.er = er;
        vecs.push_back(t);
    endtask

    // Monitor: compares each DUT response against the queued expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                exp_t e;
                exp_t a;
                int   k;
                e = exp_q.pop_front();
                k = idx_q.pop_front();
                a = {y, y_stb, frame_done, locked, sync_err};
                n_cmp++;
                if (a !== e) begin
                    n_bad++;
                    $display("FAIL vec%0d: got y=%h stb=%h fd=%b lk=%b er=%b want y=%h stb=%h fd=%b lk=%b er=%b",
                             k, a.y, a.stb, a.fd, a.lk, a.er,
                             e.y, e.stb, e.fd, e.lk, e.er);
                end
            end
        end
    end

    initial begin
        rst        = 1'b1;
        din        = 1'b0;
        din_valid  = 1'b0;
        frame_sync = 1'b0;

        //  rst v fs d   y      stb    fd lk er
        add(1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0);
        // first frame 1,0,1,1,0,0,1,0
        add(0, 1, 1, 1, 8'h01, 8'h01, 0, 1, 0);
        add(0, 1, 0, 0, 8'h01, 8'h02, 0, 1, 0);
        add(0, 1, 0, 1, 8'h05, 8'h04, 0, 1, 0);
        add(0, 1, 0, 1, 8'h0D, 8'h08, 0, 1, 0);
        add(0, 1, 0, 0, 8'h0D, 8'h10, 0, 1, 0);
        add(0, 1, 0, 0, 8'h0D, 8'h20, 0, 1, 0);
        add(0, 1, 0, 1, 8'h4D, 8'h40, 0, 1, 0);
        add(0, 1, 0, 0, 8'h4D, 8'h80, 1, 1, 0);
        // second aligned frame 0,0,1,0,1,1,0,1
        add(0, 1, 1, 0, 8'h4C, 8'h01, 0, 1, 0);
        add(0, 1, 0, 0, 8'h4C, 8'h02, 0, 1, 0);
        add(0, 1, 0, 1, 8'h4C, 8'h04, 0, 1, 0);
        add(0, 1, 0, 0, 8'h44, 8'h08, 0, 1, 0);
        add(0, 1, 0, 1, 8'h54, 8'h10, 0, 1, 0);
        add(0, 1, 0, 1, 8'h74, 8'h20, 0, 1, 0);
        add(0, 1, 0, 0, 8'h34, 8'h40, 0, 1, 0);
        add(0, 1, 0, 1, 8'hB4, 8'h80, 1, 1, 0);
        // wrap to channel 0 without sync, three samples in
        add(0, 1, 0, 0, 8'hB4, 8'h01, 0, 1, 0);
        add(0, 1, 0, 1, 8'hB6, 8'h02, 0, 1, 0);
        add(0, 1, 0, 1, 8'hB6, 8'h04, 0, 1, 0);
        // misaligned sync realigns to channel 0
        add(0, 1, 1, 1, 8'hB7, 8'h01, 0, 1, 1);
        add(0, 1, 0, 0, 8'hB5, 8'h02, 0, 1, 0);
        // sync without valid is ignored
        add(0, 0, 1, 1, 8'hB5, 8'h00, 0, 1, 0);
        // reset overrides a concurrent sync sample
        add(1, 1, 1, 1, 8'h00, 8'h00, 0, 0, 0);
        // hunt: five unsynced samples discarded
        add(0, 1, 0, 1, 8'h00, 8'h00, 0, 0, 0);
        add(0, 1, 0, 1, 8'h00, 8'h00, 0, 0, 0);
        add(0, 1, 0, 0, 8'h00, 8'h00, 0, 0, 0);
        add(0, 1, 0, 1, 8'h00, 8'h00, 0, 0, 0);
        add(0, 1, 0, 1, 8'h00, 8'h00, 0, 0, 0);
        // gapped frame with the first frame's data
        add(0, 1, 1, 1, 8'h01, 8'h01, 0, 1, 0);
        add(0, 0, 0, 0, 8'h01, 8'h00, 0, 1, 0);
        add(0, 1, 0, 0, 8'h01, 8'h02, 0, 1, 0);
        add(0, 0, 0, 1, 8'h01, 8'h00, 0, 1, 0);
        add(0, 1, 0, 1, 8'h05, 8'h04, 0, 1, 0);
        add(0, 0, 0, 0, 8'h05, 8'h00, 0, 1, 0);
        add(0, 1, 0, 1, 8'h0D, 8'h08, 0, 1, 0);
        add(0, 0, 0, 1, 8'h0D, 8'h00, 0, 1, 0);
        add(0, 1, 0, 0, 8'h0D, 8'h10, 0, 1, 0);
        add(0, 0, 0, 0, 8'h0D, 8'h00, 0, 1, 0);
        add(0, 1, 0, 0, 8'h0D, 8'h20, 0, 1, 0);
        add(0, 0, 0, 1, 8'h0D, 8'h00, 0, 1, 0);
        add(0, 1, 0, 1, 8'h4D, 8'h40, 0, 1, 0);
        add(0, 0, 0, 0, 8'h4D, 8'h00, 0, 1, 0);
        add(0, 1, 0, 0, 8'h4D, 8'h80, 1, 1, 0);
        // partial frame, then reset at channel 4
        add(0, 1, 1, 1, 8'h4D, 8'h01, 0, 1, 0);
        add(0, 1, 0, 1, 8'h4F, 8'h02, 0, 1, 0);
        add(0, 1, 0, 0, 8'h4B, 8'h04, 0, 1, 0);
        add(0, 1, 0, 0, 8'h43, 8'h08, 0, 1, 0);
        add(1, 1, 0, 1, 8'h00, 8'h00, 0, 0, 0);
        add(0, 1, 0, 1, 8'h00, 8'h00, 0, 0, 0);
        add(0, 1, 1, 0, 8'h00, 8'h01, 0, 1, 0);

        @(posedge clk);
        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            rst        = vecs[i].rst;
            din_valid  = vecs[i].v;
            frame_sync = vecs[i].fs;
            din        = vecs[i].d;
            @(posedge clk);
            exp_q.push_back(vecs[i].e);
            idx_q.push_back(i);
            #1;
        end
        din_valid  = 1'b0;
        frame_sync = 1'b0;

        for (int t = 0; t < 20 && exp_q.size() > 0; t++) begin
            @(posedge clk);
        end
        if (exp_q.size() > 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        if (n_cmp != vecs.size()) begin
            n_bad++;
            $display("FAIL count: got %0d compared want %0d", n_cmp, vecs.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/demux_8ch_tdm.md
DEMUX_8CH_TDM -- requirements
Module: demux_8ch_tdm

Interface
REQ-001 Parameter NCH, default 8, number of output channels; only the value 8 is supported.
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 din  input  1  serial TDM sample, one slot per valid cycle.
REQ-005 din_valid  input  1  din carries a sample this cycle.
REQ-006 frame_sync  input  1  qualified by din_valid; marks the current sample as channel 0.
REQ-007 y  output  8  held value per channel; bit k is the last sample routed to channel k.
REQ-008 y_stb  output  8  one-hot, one-cycle strobe; bit k high in the cycle y[k] was updated.
REQ-009 frame_done  output  1  one-cycle pulse in the cycle channel 7 is updated.
REQ-010 locked  output  1  high while in state LOCK.
REQ-011 sync_err  output  1  one-cycle pulse on a misaligned frame_sync.

Function
REQ-012 The FSM SHALL have two states: HUNT and LOCK.
REQ-013 In HUNT, din_valid with frame_sync=0 SHALL be discarded: no y, y_stb or frame_done change.
REQ-014 In HUNT, din_valid with frame_sync=1 SHALL route din to channel 0, set ch_cnt to 1 and enter LOCK.
REQ-015 In LOCK, din_valid SHALL route din to channel ch_cnt and increment the 3-bit ch_cnt, wrapping from 7 to 0.
REQ-016 In LOCK, a frame_sync with ch_cnt=0 is aligned: channel 0 is written and no error is flagged.
REQ-017 In LOCK, a frame_sync with ch_cnt!=0 SHALL realign: din goes to channel 0, ch_cnt becomes 1, sync_err pulses and the state stays LOCK.
REQ-018 frame_sync with din_valid=0 SHALL be ignored in every state.
REQ-019 Latency SHALL be 1 cycle: a sample accepted at edge n appears on y[k] and y_stb[k] after edge n.
REQ-020 Cycles with din_valid=0 SHALL hold ch_cnt, y and state, and SHALL drive y_stb=0 and frame_done=0.
REQ-021 Unwritten y bits SHALL hold their value; at most one y_stb bit SHALL be high per cycle.
REQ-022 frame_done SHALL pulse with y_stb[7], including on the wrap from 7 to 0.
REQ-023 Back-to-back valid samples SHALL be accepted every cycle with no stall; there is no backpressure.

Reset
REQ-024 rst=1 SHALL force state HUNT, ch_cnt=0, y=8'h00, y_stb=0, frame_done=0, sync_err=0 and locked=0 at the next edge.
REQ-025 rst SHALL override any concurrent din_valid or frame_sync, and reset mid-frame SHALL discard the partial frame.
REQ-026 The first sample accepted after reset deasserts SHALL be treated per the HUNT rules.

Structure
REQ-027 A shared package demux_pkg SHALL hold the state enum (HUNT, LOCK), NCH=8 and CH_W=3.
REQ-028 A single sub-module, ch_decoder_3to8, SHALL convert ch_cnt plus an enable into the one-hot write vector used for both y updates and y_stb.
REQ-029 All outputs SHALL be registered.

Verification
REQ-030 Reset then 8 valid samples 1,0,1,1,0,0,1,0 with frame_sync on the first -> y=8'b01001101, y_stb walks bit0..bit7, frame_done in the 8th output cycle, locked=1.
REQ-031 In HUNT, 5 valid samples without sync -> y=0, y_stb=0, locked=0; then a sync sample -> locked=1, y_stb=8'h01.
REQ-032 Locked, with 3 samples into a frame, frame_sync arrives with din=1 -> sync_err pulse, y[0]=1, y_stb=8'h01, next sample to channel 1.
REQ-033 din_valid toggled 1,0,1,0 across a frame -> y matches the gapless case; y_stb=0 on gap cycles; ch_cnt is unaffected by the gaps.
REQ-034 Two consecutive aligned frames -> no sync_err, two frame_done pulses exactly 8 valid samples apart, ch_cnt wraps from 7 to 0.
REQ-035 rst asserted at channel 4 -> next cycle y=0, locked=0, all strobes 0; subsequent sample without sync is discarded.
